window_line_buffer: RTL
=======================

Name: window_line_buffer

Overview:
Parametrised streaming K×K window generator that feeds the convolution stages (Sobel, Gaussian, median) in the image pipeline. It accepts one raster-order pixel per enabled clock and holds KSIZE-1 line buffers plus a KSIZE×KSIZE register window. It emits one full window per output pixel centre. It generalises the fixed 3×3 Sobel buffer with configurable data width, kernel size and border mode (valid-only or zero-padded), an input-stall rule, a flush phase and a ready handshake.

Parameters:
DATA_W, 8, pixel width in bits
KSIZE, 3, window size; odd, 3..7; H = (KSIZE-1)/2
ROWS, 5, frame height in pixels; ROWS >= KSIZE
COLS, 6, frame width in pixels; COLS >= KSIZE
PAD_MODE, 0, 0 = valid-only (no border windows); 1 = zero padding (one window per pixel)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
we_i  input  1  pixel valid; pixel accepted when we_i & ready_o
data_i  input  DATA_W  pixel, raster order
ready_o  output  1  block accepts input; low only during FLUSH
win_o  output  KSIZE*KSIZE*DATA_W  window; element k = r*KSIZE+c at bits [k*DATA_W +: DATA_W]; r=0 top row, c=0 left column
valid_o  output  1  win_o holds a new window this cycle
done_o  output  1  one-cycle pulse coincident with the last valid_o of a frame

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset values: win_o=0, valid_o=0, done_o=0, ready_o=1. Row/col counters and FSM go to RUN with position (0,0). Line-buffer RAM is not cleared; padding and counters mask stale data.
- Reset mid-frame aborts the frame. No valid_o/done_o from the partial frame. The next accepted pixel is (0,0).
- FSM states:
  - RUN: accepts pixels.
  - FLUSH: PAD_MODE=1 only, entered the cycle after pixel (ROWS-1,COLS-1) is accepted. Runs exactly H*COLS+H internal ticks, each treated as a zero pixel. ready_o=0 and we_i is ignored. Returns to RUN, position (0,0).
  - PAD_MODE=0 never enters FLUSH; ready_o is held at 1.
- Stall: a cycle with we_i=0 in RUN changes no state, and valid_o=0 that cycle. Window stream content and order do not depend on the stall pattern.
- Emission: the window centred at (y,x) is output, registered, one clock after the pixel or flush tick at linear index y*COLS+x+H*COLS+H is accepted. Windows come out in raster order of centre.
  - PAD_MODE=0: centres y in [H, ROWS-1-H], x in [H, COLS-1-H]; (ROWS-2H)*(COLS-2H) windows per frame.
  - PAD_MODE=1: all ROWS*COLS centres. Elements with row or column outside the frame are 0.
- Column wrap: elements must never mix data from the previous row's right edge. Out-of-frame columns are zeroed in mode 1; such windows are not emitted in mode 0.
- done_o: high in the same cycle as the frame's final valid_o, then counters rearm. Back-to-back frames are allowed with no gap. In PAD_MODE=1 the next frame's pixels are accepted once ready_o returns high.
- valid_o is a single-cycle strobe per window. win_o holds its value when valid_o=0.

Test Plan:
- K3, mode0, ROWS=5, COLS=6, pixels 1..30 continuous -> 12 windows. First is [1,2,3,7,8,9,13,14,15], one clock after pixel 15 is accepted. Last is [16,17,18,22,23,24,28,29,30] with done_o=1. ready_o stays 1.
- Same frame with we_i low every third cycle -> identical 12 windows in the same order. valid_o never high in a cycle following a we_i=0 cycle. done_o pulses once.
- K3, mode1, same frame -> 30 windows and ready_o=0 for exactly 7 cycles after pixel 30. First window [0,0,0,0,1,2,0,7,8], one clock after pixel 8 is accepted. Last window [23,24,0,29,30,0,0,0,0] with done_o.
- K5, mode0, ROWS=5, COLS=6 -> 2 windows: centre (2,2) = [1..5,7..11,13..17,19..23,25..29] and centre (2,3) = [2..6,8..12,14..18,20..24,26..30]. done_o on the second.
- Assert rst for one cycle after 10 pixels, then send a full 1..30 frame -> no outputs before the new frame. Exactly 12 correct windows follow; no stale data appears.
- Two back-to-back frames (1..30, then 101..130), mode0 K3 -> 24 windows and done_o twice. Second frame's first window is [101,102,103,107,108,109,113,114,115].

Source files
------------

// File: rtl/window_line_buffer_if.sv
// Pixel-in / window-out bundle for window_line_buffer.
// The producer drives we_i/data_i. The window generator drives the rest.
interface window_line_buffer_if #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3
);
  logic                            we_i;
  logic [DATA_W-1:0]               data_i;
  logic                            ready_o;
  logic [KSIZE*KSIZE*DATA_W-1:0]   win_o;
  logic                            valid_o;
  logic                            done_o;

  modport master (output we_i, data_i, input ready_o, win_o, valid_o, done_o);
  modport slave  (input we_i, data_i, output ready_o, win_o, valid_o, done_o);
endinterface

// File: rtl/window_line_buffer.sv
// Streaming KSIZE x KSIZE window generator for raster-order pixels.
// KSIZE-1 line buffers feed a column into a KSIZE-wide shift window.
// The window is masked against the frame edges and then registered.
// With PAD_MODE=1, a flush phase pushes H*COLS+H zero ticks through the
// pipeline. This lets the bottom and right border windows drain out.
module window_line_buffer #(
  parameter int DATA_W   = 8,
  parameter int KSIZE    = 3,
  parameter int ROWS     = 5,
  parameter int COLS     = 6,
  parameter int PAD_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  window_line_buffer_if.slave bus
);
  localparam int H    = (KSIZE - 1) / 2;
  localparam int NWIN = KSIZE * KSIZE;
  localparam int RW   = $clog2(ROWS + H + 1);
  localparam int CW   = $clog2(COLS);

  localparam logic [RW-1:0] ROW_ZERO       = RW'(0);
  localparam logic [RW-1:0] ROW_ONE        = RW'(1);
  localparam logic [RW-1:0] ROW_LAST       = RW'(ROWS - 1);
  localparam logic [RW-1:0] FLUSH_ROW_LAST = RW'(ROWS + H);
  localparam logic [CW-1:0] COL_ZERO       = CW'(0);
  localparam logic [CW-1:0] COL_ONE        = CW'(1);
  localparam logic [CW-1:0] COL_LAST       = CW'(COLS - 1);
  localparam logic [CW-1:0] FLUSH_COL_LAST = CW'(H - 1);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                   state_r;
  logic [RW-1:0]            ty_r;      // row of the next tick (runs past ROWS while flushing)
  logic [CW-1:0]            tx_r;      // column of the next tick
  logic                     ready_r;
  logic                     valid_r;
  logic                     done_r;
  logic [NWIN*DATA_W-1:0]   win_r;

  logic [DATA_W-1:0]        lb_r  [KSIZE-1][COLS];  // lb_r[0] is the oldest row
  logic [DATA_W-1:0]        sh_r  [KSIZE][KSIZE];   // [row][col], col KSIZE-1 newest
  logic [DATA_W-1:0]        shn_s [KSIZE][KSIZE];
  logic [DATA_W-1:0]        col_s [KSIZE];

  logic                     tick_s;
  logic [DATA_W-1:0]        pix_s;
  int                       cy_s;
  int                       cx_s;
  logic                     emit_s;
  logic                     last_s;
  logic                     frame_end_s;
  logic [NWIN*DATA_W-1:0]   win_s;

  assign bus.ready_o = ready_r;
  assign bus.win_o   = win_r;
  assign bus.valid_o = valid_r;
  assign bus.done_o  = done_r;

  // Pick the pixel for this tick: an accepted input in RUN, or a forced zero in FLUSH.
  always_comb begin
    tick_s = 1'b0;
    pix_s  = {DATA_W{1'b0}};
    if (state_r == FLUSH) begin
      tick_s = 1'b1;
      pix_s  = {DATA_W{1'b0}};
    end else begin
      tick_s = bus.we_i;
      pix_s  = bus.data_i;
    end
  end

  // Form the incoming column: older rows come from the line buffers, and the newest row is the pixel itself.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) col_s[r] = {DATA_W{1'b0}};
    for (int r = 0; r < KSIZE - 1; r++) col_s[r] = lb_r[r][tx_r];
    col_s[KSIZE-1] = pix_s;
  end

  // Compute the window contents after this tick: shift left by one column and append the new column.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) shn_s[r][c] = sh_r[r][c+1];
      shn_s[r][KSIZE-1] = col_s[r];
    end
  end

  // Find the centre completed by this tick. Columns left of H belong to a centre on the previous row.
  always_comb begin
    cy_s = 0;
    cx_s = 0;
    if (int'(tx_r) >= H) begin
      cy_s = int'(ty_r) - H;
      cx_s = int'(tx_r) - H;
    end else begin
      cy_s = int'(ty_r) - H - 1;
      cx_s = int'(tx_r) - H + COLS;
    end
  end

  // Zero every element outside the frame. This also hides row-wrap data and stale line-buffer contents.
  always_comb begin
    win_s = {(NWIN*DATA_W){1'b0}};
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        if ((cy_s - H + r >= 0) && (cy_s - H + r < ROWS) &&
            (cx_s - H + c >= 0) && (cx_s - H + c < COLS)) begin
          win_s[(r*KSIZE+c)*DATA_W +: DATA_W] = shn_s[r][c];
        end else begin
          win_s[(r*KSIZE+c)*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        end
      end
    end
  end

  // Decide whether this tick emits a window, and whether that window is the last of the frame.
  always_comb begin
    emit_s      = 1'b0;
    last_s      = 1'b0;
    frame_end_s = (state_r == RUN) && (ty_r == ROW_LAST) && (tx_r == COL_LAST);
    if (PAD_MODE != 0) begin
      emit_s = tick_s && (cy_s >= 0);
      last_s = (state_r == FLUSH) && (ty_r == FLUSH_ROW_LAST) && (tx_r == FLUSH_COL_LAST);
    end else begin
      emit_s = tick_s && (int'(ty_r) >= KSIZE - 1) && (int'(tx_r) >= KSIZE - 1);
      last_s = frame_end_s;
    end
  end

  // Rotate the line buffers at the current column. They are never cleared; masking covers stale data.
  always_ff @(posedge clk) begin
    if (tick_s) begin
      for (int j = 0; j < KSIZE - 2; j++) lb_r[j][tx_r] <= lb_r[j+1][tx_r];
      lb_r[KSIZE-2][tx_r] <= pix_s;
    end
  end

  // Run/flush FSM, raster position counters, shift window and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      ty_r    <= ROW_ZERO;
      tx_r    <= COL_ZERO;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      win_r   <= {(NWIN*DATA_W){1'b0}};
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) sh_r[r][c] <= {DATA_W{1'b0}};
    end else begin
      valid_r <= emit_s;
      done_r  <= emit_s && last_s;
      if (emit_s) win_r <= win_s;
      if (tick_s) begin
        sh_r <= shn_s;
        case (state_r)
          RUN: begin
            if (frame_end_s && (PAD_MODE != 0)) begin
              state_r <= FLUSH;
              ready_r <= 1'b0;
              ty_r    <= ty_r + ROW_ONE;
              tx_r    <= COL_ZERO;
            end else if (frame_end_s) begin
              ty_r <= ROW_ZERO;
              tx_r <= COL_ZERO;
            end else if (tx_r == COL_LAST) begin
              ty_r <= ty_r + ROW_ONE;
              tx_r <= COL_ZERO;
            end else begin
              tx_r <= tx_r + COL_ONE;
            end
          end
          FLUSH: begin
            if (last_s) begin
              state_r <= RUN;
              ready_r <= 1'b1;
              ty_r    <= ROW_ZERO;
              tx_r    <= COL_ZERO;
            end else if (tx_r == COL_LAST) begin
              ty_r <= ty_r + ROW_ONE;
              tx_r <= COL_ZERO;
            end else begin
              tx_r <= tx_r + COL_ONE;
            end
          end
          default: begin
            state_r <= RUN;
            ready_r <= 1'b1;
            ty_r    <= ROW_ZERO;
            tx_r    <= COL_ZERO;
          end
        endcase
      end
    end
  end
endmodule
